// File: rtl/stage_fetch_if.sv
// Instruction-memory channel between the fetch stage and instruction memory.
// Request: out_mem_req_valid / out_mem_req_addr from fetch, in_mem_req_ready from memory.
// Response: in_mem_resp_valid / in_mem_resp_data from memory (valid-only, no backpressure).
// Signal names are as seen from the fetch stage.
interface stage_fetch_if;
   logic        out_mem_req_valid;
   logic [31:0] out_mem_req_addr;
   logic        in_mem_req_ready;
   logic        in_mem_resp_valid;
   logic [31:0] in_mem_resp_data;

   // Fetch side
   modport master (
      output out_mem_req_valid,
      output out_mem_req_addr,
      input  in_mem_req_ready,
      input  in_mem_resp_valid,
      input  in_mem_resp_data
   );

   // Memory side
   modport slave (
      input  out_mem_req_valid,
      input  out_mem_req_addr,
      output in_mem_req_ready,
      output in_mem_resp_valid,
      output in_mem_resp_data
   );
endinterface

// File: rtl/stage_fetch.sv
// Instruction-fetch stage. Holds the PC, issues single-outstanding word fetches,
// and hands instructions to decode through an output slot backed by a one-entry
// skid buffer. Taken-branch redirects flush the slots and discard stale responses.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   in_stall                  : decode holds the current output this cycle
//   in_branch_taken/target    : redirect request and target (bits [1:0] ignored)
//   mem                       : instruction-memory channel (master side)
//   out_instruction/PC/valid  : instruction to decode (NOP / 0 when not valid)
module stage_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_stall,
   input  logic              in_branch_taken,
   input  logic [31:0]       in_branch_target,
   stage_fetch_if.master     mem,
   output logic [31:0]       out_instruction,
   output logic [31:0]       out_PC,
   output logic              out_valid
);
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP       = 32'h0000_0013;
   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [XLEN-1:0] PC_INIT   = RESET_PC & WORD_MASK;

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_pc;
   logic            skid_valid;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;

   logic            req_fire;
   logic            deliver;
   logic            consume;
   logic [XLEN-1:0] target_aligned;

   // Request is offered only from REQ, with room in the skid, and never in a redirect cycle
   assign mem.out_mem_req_valid = !reset && (state == ST_REQ) && !skid_valid && !in_branch_taken;
   assign mem.out_mem_req_addr  = pc;

   assign req_fire       = mem.out_mem_req_valid && mem.in_mem_req_ready;
   assign deliver        = (state == ST_WAIT) && mem.in_mem_resp_valid;
   assign consume        = out_valid && !in_stall;
   assign target_aligned = in_branch_target & WORD_MASK;

   // FSM, PC, output slot and skid slot
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_REQ;
         pc              <= PC_INIT;
         req_pc          <= '0;
         out_valid       <= 1'b0;
         out_instruction <= NOP;
         out_PC          <= '0;
         skid_valid      <= 1'b0;
         skid_instr      <= NOP;
         skid_pc         <= '0;
      end else if (in_branch_taken) begin
         // Redirect wins: flush both slots; an outstanding request must be drained
         pc              <= target_aligned;
         out_valid       <= 1'b0;
         out_instruction <= NOP;
         out_PC          <= '0;
         skid_valid      <= 1'b0;
         case (state)
            ST_WAIT:  state <= mem.in_mem_resp_valid ? ST_REQ : ST_DRAIN;
            ST_DRAIN: state <= mem.in_mem_resp_valid ? ST_REQ : ST_DRAIN;
            default:  state <= ST_REQ;
         endcase
      end else begin
         case (state)
            ST_REQ: begin
               if (req_fire) begin
                  req_pc <= pc;
                  pc     <= pc + PC_STEP;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem.in_mem_resp_valid) state <= ST_REQ;
            end
            ST_DRAIN: begin
               // Stale response from before a redirect: dropped
               if (mem.in_mem_resp_valid) state <= ST_REQ;
            end
            default: state <= ST_REQ;
         endcase

         // Skid is never full while a response can arrive, so skid and deliver are exclusive
         if (consume) begin
            if (skid_valid) begin
               out_instruction <= skid_instr;
               out_PC          <= skid_pc;
               skid_valid      <= 1'b0;
            end else if (deliver) begin
               out_instruction <= mem.in_mem_resp_data;
               out_PC          <= req_pc;
            end else begin
               out_valid       <= 1'b0;
               out_instruction <= NOP;
               out_PC          <= '0;
            end
         end else if (!out_valid) begin
            if (deliver) begin
               out_valid       <= 1'b1;
               out_instruction <= mem.in_mem_resp_data;
               out_PC          <= req_pc;
            end
         end else if (deliver) begin
            skid_valid <= 1'b1;
            skid_instr <= mem.in_mem_resp_data;
            skid_pc    <= req_pc;
         end
      end
   end
endmodule

// File: tb/tb_stage_fetch.sv
// Directed testbench for stage_fetch. Two instances share all inputs; dut0 uses
// the default reset PC, dut1 resets to 32'hFFFF_FFF8 to exercise PC wraparound.
// Memory data for address a is a ^ 32'hA5A5_0000.
module tb_stage_fetch;
   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch;
   logic [31:0] target;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   logic [31:0] o0_instr, o0_pc, o1_instr, o1_pc;
   logic        o0_valid, o1_valid;

   int total;
   int passed;

   stage_fetch_if mem0();
   stage_fetch_if mem1();

   assign mem0.in_mem_req_ready  = ready;
   assign mem0.in_mem_resp_valid = rvalid;
   assign mem0.in_mem_resp_data  = rdata;
   assign mem1.in_mem_req_ready  = ready;
   assign mem1.in_mem_resp_valid = rvalid;
   assign mem1.in_mem_resp_data  = rdata;

   stage_fetch dut0 (
      .clk(clk), .reset(reset), .in_stall(stall),
      .in_branch_taken(branch), .in_branch_target(target),
      .mem(mem0),
      .out_instruction(o0_instr), .out_PC(o0_pc), .out_valid(o0_valid)
   );

   stage_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .reset(reset), .in_stall(stall),
      .in_branch_taken(branch), .in_branch_target(target),
      .mem(mem1),
      .out_instruction(o1_instr), .out_PC(o1_pc), .out_valid(o1_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   // One clock cycle: inputs change 1ns after the rising edge, outputs checked 1ns later
   task automatic drive(input logic rs, input logic br, input logic [31:0] tg,
                        input logic st, input logic rd, input logic vv,
                        input logic [31:0] dt);
      @(posedge clk); #1;
      reset = rs; branch = br; target = tg; stall = st;
      ready = rd; rvalid = vv; rdata = dt;
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 0, 0);
      total++; if (o0_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o0_valid); else passed++;
      total++; if (o0_instr !== 32'h0000_0013) $display("FAIL reset_instr got %h exp 00000013", o0_instr); else passed++;
      total++; if (o0_pc !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", o0_pc); else passed++;
      total++; if (mem0.out_mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", mem0.out_mem_req_valid); else passed++;
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'(4 * i);
         drive(0, 0, 0, 0, 1, 0, 0);
         total++; if (mem0.out_mem_req_valid !== 1'b1) $display("FAIL stream_req_valid[%0d] got %b exp 1", i, mem0.out_mem_req_valid); else passed++;
         total++; if (mem0.out_mem_req_addr !== a) $display("FAIL stream_req_addr[%0d] got %h exp %h", i, mem0.out_mem_req_addr, a); else passed++;
         if (i > 0) begin
            total++; if (o0_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", i, o0_valid); else passed++;
            total++; if (o0_pc !== a - 32'h4) $display("FAIL stream_pc[%0d] got %h exp %h", i, o0_pc, a - 32'h4); else passed++;
            total++; if (o0_instr !== dat(a - 32'h4)) $display("FAIL stream_instr[%0d] got %h exp %h", i, o0_instr, dat(a - 32'h4)); else passed++;
         end
         drive(0, 0, 0, 0, 1, 1, dat(a));
         total++; if (mem0.out_mem_req_valid !== 1'b0) $display("FAIL stream_wait_req[%0d] got %b exp 0", i, mem0.out_mem_req_valid); else passed++;
         total++; if (o0_valid !== 1'b0) $display("FAIL stream_gap_valid[%0d] got %b exp 0", i, o0_valid); else passed++;
      end
   endtask

   task automatic test_stall();
      do_reset();
      drive(0, 0, 0, 1, 1, 0, 0);                   // accept 1000
      drive(0, 0, 0, 1, 0, 1, dat(32'h1000));       // response -> output slot
      total++; if (o0_valid !== 1'b0) $display("FAIL stall_pre_valid got %b exp 0", o0_valid); else passed++;
      drive(0, 0, 0, 1, 1, 0, 0);                   // accept 1004
      total++; if (mem0.out_mem_req_addr !== 32'h1004 || mem0.out_mem_req_valid !== 1'b1)
         $display("FAIL stall_second_req got %b/%h exp 1/00001004", mem0.out_mem_req_valid, mem0.out_mem_req_addr); else passed++;
      drive(0, 0, 0, 1, 0, 1, dat(32'h1004));       // response -> skid
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 1, 0, 0);
         total++; if (mem0.out_mem_req_valid !== 1'b0) $display("FAIL stall_no_third_req[%0d] got %b exp 0", i, mem0.out_mem_req_valid); else passed++;
         total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h1000) $display("FAIL stall_hold[%0d] got %b/%h exp 1/00001000", i, o0_valid, o0_pc); else passed++;
      end
      drive(0, 0, 0, 0, 0, 0, 0);                   // release
      total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h1000 || o0_instr !== dat(32'h1000))
         $display("FAIL stall_rel0 got %b/%h/%h exp 1/00001000/%h", o0_valid, o0_pc, o0_instr, dat(32'h1000)); else passed++;
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h1004 || o0_instr !== dat(32'h1004))
         $display("FAIL stall_rel1 got %b/%h/%h exp 1/00001004/%h", o0_valid, o0_pc, o0_instr, dat(32'h1004)); else passed++;
      total++; if (mem0.out_mem_req_valid !== 1'b1 || mem0.out_mem_req_addr !== 32'h1008)
         $display("FAIL stall_next_req got %b/%h exp 1/00001008", mem0.out_mem_req_valid, mem0.out_mem_req_addr); else passed++;
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b0) $display("FAIL stall_no_dup got %b exp 0", o0_valid); else passed++;
      total++; if (mem0.out_mem_req_addr !== 32'h1008) $display("FAIL stall_addr_hold got %h exp 00001008", mem0.out_mem_req_addr); else passed++;
   endtask

   task automatic test_ready_low();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         total++; if (mem0.out_mem_req_valid !== 1'b1 || mem0.out_mem_req_addr !== 32'h1000)
            $display("FAIL ready_low_hold[%0d] got %b/%h exp 1/00001000", i, mem0.out_mem_req_valid, mem0.out_mem_req_addr); else passed++;
      end
      drive(0, 0, 0, 0, 1, 0, 0);
      total++; if (mem0.out_mem_req_addr !== 32'h1000) $display("FAIL ready_low_accept got %h exp 00001000", mem0.out_mem_req_addr); else passed++;
      drive(0, 0, 0, 0, 0, 1, dat(32'h1000));
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h1000) $display("FAIL ready_low_out got %b/%h exp 1/00001000", o0_valid, o0_pc); else passed++;
      total++; if (mem0.out_mem_req_addr !== 32'h1004) $display("FAIL ready_low_next got %h exp 00001004", mem0.out_mem_req_addr); else passed++;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      drive(0, 0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 1, dat(32'h1000));
      drive(0, 0, 0, 0, 1, 0, 0);                   // out 1000, accept 1004
      drive(0, 0, 0, 0, 1, 1, dat(32'h1004));
      drive(0, 0, 0, 0, 1, 0, 0);                   // out 1004, accept 1008
      drive(0, 1, 32'h2002, 0, 1, 0, 0);            // redirect while waiting
      total++; if (mem0.out_mem_req_valid !== 1'b0) $display("FAIL redir_wait_req got %b exp 0", mem0.out_mem_req_valid); else passed++;
      drive(0, 0, 0, 0, 1, 0, 0);
      total++; if (o0_valid !== 1'b0 || o0_instr !== 32'h0000_0013 || o0_pc !== 32'h0)
         $display("FAIL redir_wait_flush got %b/%h/%h exp 0/00000013/00000000", o0_valid, o0_instr, o0_pc); else passed++;
      total++; if (mem0.out_mem_req_valid !== 1'b0) $display("FAIL redir_wait_drain_req got %b exp 0", mem0.out_mem_req_valid); else passed++;
      drive(0, 0, 0, 0, 1, 1, dat(32'h1008));       // stale response
      drive(0, 0, 0, 0, 1, 0, 0);
      total++; if (o0_valid !== 1'b0) $display("FAIL redir_wait_stale got %b exp 0", o0_valid); else passed++;
      total++; if (mem0.out_mem_req_valid !== 1'b1 || mem0.out_mem_req_addr !== 32'h2000)
         $display("FAIL redir_wait_target got %b/%h exp 1/00002000", mem0.out_mem_req_valid, mem0.out_mem_req_addr); else passed++;
      drive(0, 0, 0, 0, 1, 1, dat(32'h2000));
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h2000 || o0_instr !== dat(32'h2000))
         $display("FAIL redir_wait_out got %b/%h/%h exp 1/00002000/%h", o0_valid, o0_pc, o0_instr, dat(32'h2000)); else passed++;
   endtask

   task automatic test_redirect_resp();
      do_reset();
      drive(0, 0, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 1, dat(32'h1000));
      drive(0, 0, 0, 1, 1, 0, 0);                   // out 1000 held, accept 1004
      drive(0, 1, 32'h3000, 1, 0, 1, dat(32'h1004)); // redirect with response, stalled
      drive(0, 0, 0, 1, 1, 0, 0);
      total++; if (o0_valid !== 1'b0) $display("FAIL redir_resp_flush got %b exp 0", o0_valid); else passed++;
      total++; if (mem0.out_mem_req_valid !== 1'b1 || mem0.out_mem_req_addr !== 32'h3000)
         $display("FAIL redir_resp_target got %b/%h exp 1/00003000", mem0.out_mem_req_valid, mem0.out_mem_req_addr); else passed++;
      drive(0, 0, 0, 0, 0, 1, dat(32'h3000));
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b1 || o0_pc !== 32'h3000) $display("FAIL redir_resp_out got %b/%h exp 1/00003000", o0_valid, o0_pc); else passed++;
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o0_valid !== 1'b0) $display("FAIL redir_resp_skid_clear got %b exp 0", o0_valid); else passed++;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         logic [31:0] a;
         a = 32'hFFFF_FFF8 + 32'(4 * i);
         drive(0, 0, 0, 0, 1, 0, 0);
         total++; if (mem1.out_mem_req_valid !== 1'b1 || mem1.out_mem_req_addr !== a)
            $display("FAIL wrap_req[%0d] got %b/%h exp 1/%h", i, mem1.out_mem_req_valid, mem1.out_mem_req_addr, a); else passed++;
         if (i > 0) begin
            total++; if (o1_valid !== 1'b1 || o1_pc !== a - 32'h4)
               $display("FAIL wrap_out[%0d] got %b/%h exp 1/%h", i, o1_valid, o1_pc, a - 32'h4); else passed++;
         end
         drive(0, 0, 0, 0, 1, 1, dat(a));
      end
      drive(0, 0, 0, 1, 1, 0, 0);                   // out PC 0 held, accept 4 -> WAIT
      total++; if (o1_valid !== 1'b1 || o1_pc !== 32'h0 || o1_instr !== 32'hA5A5_0000)
         $display("FAIL wrap_zero got %b/%h/%h exp 1/00000000/a5a50000", o1_valid, o1_pc, o1_instr); else passed++;
      drive(1, 0, 0, 1, 0, 0, 0);                   // reset while waiting
      total++; if (o1_valid !== 1'b1) $display("FAIL wrap_pre_reset got %b exp 1", o1_valid); else passed++;
      drive(0, 0, 0, 0, 0, 0, 0);
      total++; if (o1_valid !== 1'b0 || o1_instr !== 32'h0000_0013 || o1_pc !== 32'h0)
         $display("FAIL wrap_reset_out got %b/%h/%h exp 0/00000013/00000000", o1_valid, o1_instr, o1_pc); else passed++;
      total++; if (mem1.out_mem_req_valid !== 1'b1 || mem1.out_mem_req_addr !== 32'hFFFF_FFF8)
         $display("FAIL wrap_reset_req got %b/%h exp 1/fffffff8", mem1.out_mem_req_valid, mem1.out_mem_req_addr); else passed++;
   endtask

   initial begin
      total = 0; passed = 0;
      reset = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
      ready = 1'b0; rvalid = 1'b0; rdata = '0;
      test_reset();
      test_stream();
      test_stall();
      test_ready_low();
      test_redirect_wait();
      test_redirect_resp();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction-fetch stage (IF), directly upstream of decode. Holds the program counter and issues single-outstanding word requests to instruction memory over a valid/ready request channel plus a valid-only response channel. Delivers `out_instruction` / `out_PC` / `out_valid` to decode, with a one-entry skid buffer so a stalled decode never loses a returning instruction. Accepts taken-branch redirects and discards any in-flight response they make stale.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_1000: PC loaded on reset. Bits [1:0] must be 0.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_stall` in 1: decode/hazard unit holds the current output; it is not consumed this cycle.
- `in_branch_taken` in 1: redirect request from a later stage.
- `in_branch_target` in 32: redirect address; bits [1:0] are forced to 0.
- `out_mem_req_valid` out 1: a fetch request is presented.
- `out_mem_req_addr` out 32: word address of the request (the current PC).
- `in_mem_req_ready` in 1: memory accepts the request this cycle.
- `in_mem_resp_valid` in 1: response data valid; at most one per accepted request, any later cycle.
- `in_mem_resp_data` in 32: the fetched instruction word.
- `out_instruction` out 32: instruction to decode; 32'h0000_0013 (NOP) whenever `out_valid`=0.
- `out_PC` out 32: PC of `out_instruction`; 0 when `out_valid`=0.
- `out_valid` out 1: output slot holds a real instruction.

## Operation

- Registers:
  - `pc`: next address to fetch.
  - `req_pc`: address of the outstanding request.
  - Output slot: instruction, PC, valid.
  - Skid slot: instruction, PC, valid.
  - FSM state.
- FSM states:
  - **REQ**: `out_mem_req_valid` = skid empty and no redirect this cycle. On `in_mem_req_ready` with valid: `req_pc`<=`pc`, `pc`<=`pc`+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - **WAIT**: no request. On `in_mem_resp_valid`, deliver (PC=`req_pc`), go to REQ.
  - **DRAIN**: no request. On `in_mem_resp_valid`, discard the data, go to REQ.
- Delivery of a response:
  - Output slot empty, or consumed this cycle (`out_valid` && !`in_stall`): the response goes into the output slot.
  - Otherwise: the response goes into the skid slot.
  - The skid slot is always empty when a response arrives, because a request is only issued while skid is empty and only one request is ever outstanding.
- Consumption:
  - `out_valid` && !`in_stall`: the output slot takes the skid contents if skid is valid; else the response (if delivered); else it empties.
  - `in_stall` with `out_valid`=1: output slot unchanged.
- Redirect (`in_branch_taken`=1) has priority over everything:
  - `pc`<=`{in_branch_target[31:2],2'b00}`.
  - Output and skid valids are cleared.
  - No request is issued that cycle.
  - State transitions:
    - WAIT goes to DRAIN, unless `in_mem_resp_valid` is high the same cycle; then that response is dropped and the state goes to REQ.
    - DRAIN stays DRAIN, unless a response arrives the same cycle; then it is dropped and the state goes to REQ.
    - REQ stays REQ.
- `in_stall` has no effect on redirect handling or on the memory handshake, except through the skid-full condition.

## Timing

- Reset (synchronous, while `reset`=1):
  - `pc`=`RESET_PC`; state=REQ.
  - `out_valid`=0, `out_instruction`=32'h0000_0013, `out_PC`=0.
  - Skid empty; `out_mem_req_valid`=0 during reset cycles.
  - Reset mid-transaction abandons the outstanding request. The memory side is reset concurrently, so no stale response is expected.
- First request: `out_mem_req_valid`=1, addr=`RESET_PC` in the first cycle after `reset` falls.
- Latency: a response in cycle N is visible on `out_*` in cycle N+1.
- Throughput:
  - Zero-wait memory (ready=1, response the cycle after accept): one instruction per 2 cycles.
  - The next request is presented the cycle after a response.
- Request signals are registered/state-derived plus combinational gating by `in_branch_taken` and skid state. `out_mem_req_addr` is stable while valid && !ready, unless a redirect intervenes.
- Redirect in cycle N: `out_valid`=0 in N+1; the first request to the target appears in N+1 (from REQ) or the cycle after the stale response (from DRAIN).

## Test plan

- Reset, then ready=1 and 1-cycle response memory returning `addr`^32'hA5A5_0000:
  - `out_valid` pulses every other cycle.
  - `out_PC` = 0x1000, 0x1004, 0x1008…
  - `out_instruction` matches the data for each PC.
- `in_stall` held high for 6 cycles while two responses are pending:
  - The first response is held in the output slot and the second in skid.
  - No third request is issued.
  - On release, outputs 0x1000 then 0x1004 appear on consecutive cycles; nothing is lost or duplicated.
- Redirect to 0x2002 while in WAIT (response for 0x1008 due later):
  - The stale response is discarded.
  - The next request address is 0x2000.
  - The next valid output has `out_PC`=0x2000.
  - `out_valid`=0 in the cycle after the redirect.
- Redirect in the same cycle as `in_mem_resp_valid`, with stall high:
  - The response is dropped and the skid is cleared.
  - The next request goes to the target.
- `in_mem_req_ready` low for 5 cycles:
  - `out_mem_req_valid`/addr are held constant.
  - `pc` does not advance.
- `RESET_PC`=32'hFFFF_FFF8: fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000. Also assert `reset` while in WAIT: outputs return to reset values the next cycle.
